// File: rtl/imem_loader.sv
// Instruction-memory loader: takes 32-bit words on a valid/ready stream and writes each one as 4 little-endian bytes.
// Latency: word accepted at edge N, bytes land at edges N+1..N+4, ready again the cycle after; at most 1 word per 5 cycles.
// Backpressure: in_ready is high only while waiting for a word; a word that would not fit is dropped and flagged on err.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr            open a session at base_addr (low two bits ignored), sampled only when idle
//   in_valid/in_ready/in_word/in_last  instruction word stream; in_last closes the session
//   mem_we/mem_addr/mem_wdata   byte write port toward the instruction memory (addr/data are 0 when mem_we=0)
//   busy, done, err             session active, one-cycle end pulse, sticky overflow flag
//   word_count, checksum        words written this session; running XOR of written words
// Build option: define IMEM_LOADER_CHECKSUM_EN to keep the checksum register; otherwise checksum reads 0.

module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR0,
        S_WR1,
        S_WR2,
        S_WR3,
        S_DONE
    } state_t;

    // One extra bit lets the address reach MEM_BYTES itself without wrapping to 0.
    localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ADDR_W+1:0] end_addr;
    logic              fits;
    logic              we;
    logic [1:0]        byte_sel;

    assign end_addr = {1'b0, addr_q} + (ADDR_W+2)'(4);
    assign fits     = (end_addr <= MEM_LIMIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        we       = 1'b0;
        byte_sel = 2'd0;
        in_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = {1'b0, base_addr & ~ADDR_W'(3)};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d = in_word;
                    last_d = in_last;
                    if (fits) begin
                        state_d = S_WR0;
                    end else begin
                        // No room for all four bytes: drop the whole word rather than write part of it.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WR0: begin
                we       = 1'b1;
                byte_sel = 2'd0;
                state_d  = S_WR1;
            end
            S_WR1: begin
                we       = 1'b1;
                byte_sel = 2'd1;
                state_d  = S_WR2;
            end
            S_WR2: begin
                we       = 1'b1;
                byte_sel = 2'd2;
                state_d  = S_WR3;
            end
            S_WR3: begin
                we       = 1'b1;
                byte_sel = 2'd3;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + (ADDR_W+1)'(4);
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Address/data are forced to 0 when not writing so every output is 0 in reset.
    assign mem_we     = we;
    assign mem_addr   = we ? (addr_q[ADDR_W-1:0] + ADDR_W'(byte_sel)) : '0;
    assign mem_wdata  = we ? word_q[8*byte_sel +: 8] : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign word_count = cnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE && start) begin
            csum_d = '0;
        end else if (state_q == S_WR3) begin
            csum_d = csum_q ^ word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
